btn_event_gen: RTL and testbench

Front-panel button conditioner on the CPU clock domain.
- Takes the already-synchronized active-low button inputs (btn_LL) and produces debounced levels.
- Generates press, long-press, auto-repeat and release events for them.
- Keeps sticky event flags and an 8-bit event counter.
- Outputs are packed into the controls input PIO, replacing raw button bits, so firmware polls events exactly as it polls ir_code_cnt.

---
 rtl/btn_event_pkg.sv | 42 ++++
 rtl/btn_fsm.sv | 124 ++++++++++++
 rtl/btn_event_gen.sv | 104 ++++++++++
 tb/tb_btn_event_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types and defaults for the front-panel button conditioner.
// Durations are counted in ms ticks; events are one-hot per button, indexed by evt_type_e.
package btn_event_pkg;

  localparam int MS_CNT_W = 16;

  localparam int          DEF_NUM_BTN     = 2;
  localparam int unsigned DEF_CLKS_PER_MS = 27000;
  localparam int unsigned DEF_DEBOUNCE_MS = 20;
  localparam int unsigned DEF_LONG_MS     = 1500;
  localparam int unsigned DEF_REPEAT_MS   = 200;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    PRESSED  = 3'd2,
    HELD     = 3'd3,
    DB_REL   = 3'd4
  } btn_state_e;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_type_e;

  localparam int NUM_EVT_TYPES = 4;

  typedef logic [MS_CNT_W-1:0] ms_cnt_t;

  // Saturating increment so a very long hold cannot wrap back into a match.
  function automatic ms_cnt_t ms_inc(input ms_cnt_t c);
    return (c == '1) ? c : c + ms_cnt_t'(1);
  endfunction

  // True when the tick being taken now completes a duration of n ms.
  function automatic logic ms_reached(input ms_cnt_t c, input int unsigned n);
    return (32'(c) + 32'd1) == n;
  endfunction

endpackage

// File: rtl/btn_fsm.sv
// Per-button debounce / long-press / auto-repeat state machine.
// Event pulses are registered with the transition that produces them.
module btn_fsm
  import btn_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = DEF_LONG_MS,
  parameter int unsigned REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic                     clk27,
  input  logic                     reset,
  input  logic                     btn_n,
  input  logic                     tick,
  output logic                     level,
  output logic [NUM_EVT_TYPES-1:0] evt,
  output btn_state_e               state
);

  btn_state_e                 state_q, state_d;
  ms_cnt_t                    ms_cnt_q, ms_cnt_d;
  logic                       long_fired_q, long_fired_d;
  logic [NUM_EVT_TYPES-1:0]   evt_q, evt_d;
  logic                       pressed;

  assign pressed = ~btn_n;

  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ms_cnt_q     <= '0;
      long_fired_q <= 1'b0;
      evt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ms_cnt_q     <= ms_cnt_d;
      long_fired_q <= long_fired_d;
      evt_q        <= evt_d;
    end
  end

  // Raw-input changes are examined before the tick, so a change always restarts timing.
  always_comb begin
    state_d      = state_q;
    ms_cnt_d     = ms_cnt_q;
    long_fired_d = long_fired_q;
    evt_d        = '0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d  = DB_PRESS;
          ms_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!pressed) begin
          state_d  = IDLE;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_reached(ms_cnt_q, DEBOUNCE_MS)) begin
            state_d          = PRESSED;
            ms_cnt_d         = '0;
            long_fired_d     = 1'b0;
            evt_d[EVT_PRESS] = 1'b1;
          end else begin
            ms_cnt_d = ms_inc(ms_cnt_q);
          end
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d  = DB_REL;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_reached(ms_cnt_q, LONG_MS)) begin
            state_d         = HELD;
            ms_cnt_d        = '0;
            long_fired_d    = 1'b1;
            evt_d[EVT_LONG] = 1'b1;
          end else begin
            ms_cnt_d = ms_inc(ms_cnt_q);
          end
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d  = DB_REL;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_reached(ms_cnt_q, REPEAT_MS)) begin
            ms_cnt_d          = '0;
            evt_d[EVT_REPEAT] = 1'b1;
          end else begin
            ms_cnt_d = ms_inc(ms_cnt_q);
          end
        end
      end
      DB_REL: begin
        if (pressed) begin
          state_d  = long_fired_q ? HELD : PRESSED;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_reached(ms_cnt_q, DEBOUNCE_MS)) begin
            state_d            = IDLE;
            ms_cnt_d           = '0;
            evt_d[EVT_RELEASE] = 1'b1;
          end else begin
            ms_cnt_d = ms_inc(ms_cnt_q);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        ms_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    level = (state_q == PRESSED) || (state_q == HELD) || (state_q == DB_REL);
    evt   = evt_q;
    state = state_q;
  end

endmodule

// File: rtl/btn_event_gen.sv
// Button conditioner top: shared ms prescaler, one btn_fsm per button,
// sticky event flags and a wrapping event counter for firmware polling.
module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int          NUM_BTN     = DEF_NUM_BTN,
  parameter int unsigned CLKS_PER_MS = DEF_CLKS_PER_MS,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = DEF_LONG_MS,
  parameter int unsigned REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic                      clk27,
  input  logic                      reset,
  input  logic [NUM_BTN-1:0]        btn_n,
  input  logic                      evt_clr,
  output logic [NUM_BTN-1:0]        btn_level,
  output logic [NUM_BTN-1:0]        evt_press,
  output logic [NUM_BTN-1:0]        evt_long,
  output logic [NUM_BTN-1:0]        evt_repeat,
  output logic [NUM_BTN-1:0]        evt_release,
  output logic [7:0]                evt_cnt,
  output logic [NUM_BTN-1:0][2:0]   dbg_state
);

  if (DEBOUNCE_MS < 1 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_ms
    $error("btn_event_gen: DEBOUNCE_MS, LONG_MS and REPEAT_MS must be >= 1");
  end
  if (CLKS_PER_MS < 2) begin : g_bad_presc
    $error("btn_event_gen: CLKS_PER_MS must be >= 2");
  end
  if (NUM_BTN < 1) begin : g_bad_num
    $error("btn_event_gen: NUM_BTN must be >= 1");
  end

  localparam int PRESC_W = $clog2(CLKS_PER_MS);

  logic [PRESC_W-1:0]                      presc_q;
  logic                                    tick;
  logic [NUM_BTN-1:0]                      fsm_level;
  logic [NUM_BTN-1:0][NUM_EVT_TYPES-1:0]   evt_pulse;
  logic [NUM_BTN-1:0]                      pulse_press, pulse_long, pulse_repeat, pulse_release;
  logic [7:0]                              evt_sum;

  // Free-running; button activity never disturbs the tick phase.
  assign tick = (presc_q == PRESC_W'(CLKS_PER_MS - 1));

  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_fsm #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_fsm (
      .clk27 (clk27),
      .reset (reset),
      .btn_n (btn_n[i]),
      .tick  (tick),
      .level (fsm_level[i]),
      .evt   (evt_pulse[i]),
      .state (dbg_state[i])
    );
  end

  // 8-bit accumulation is exact because evt_cnt itself wraps mod 256.
  always_comb begin
    evt_sum = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      pulse_press[i]   = evt_pulse[i][EVT_PRESS];
      pulse_long[i]    = evt_pulse[i][EVT_LONG];
      pulse_repeat[i]  = evt_pulse[i][EVT_REPEAT];
      pulse_release[i] = evt_pulse[i][EVT_RELEASE];
      for (int t = 0; t < NUM_EVT_TYPES; t++) begin
        evt_sum = evt_sum + {7'd0, evt_pulse[i][t]};
      end
    end
  end

  // A new event outranks a simultaneous clear on its own bit.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      btn_level   <= '0;
      evt_press   <= '0;
      evt_long    <= '0;
      evt_repeat  <= '0;
      evt_release <= '0;
      evt_cnt     <= '0;
    end else begin
      btn_level   <= fsm_level;
      evt_press   <= (evt_clr ? '0 : evt_press)   | pulse_press;
      evt_long    <= (evt_clr ? '0 : evt_long)    | pulse_long;
      evt_repeat  <= (evt_clr ? '0 : evt_repeat)  | pulse_repeat;
      evt_release <= (evt_clr ? '0 : evt_release) | pulse_release;
      evt_cnt     <= evt_cnt + evt_sum;
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: directed scenarios plus random button activity,
// checked against a disagreement-run reference model of the button rules.
module tb_btn_event_gen;

  localparam int NB  = 2;
  localparam int CPM = 10;
  localparam int DB  = 2;
  localparam int LG  = 5;
  localparam int RP  = 2;

  logic              clk27 = 1'b0;
  logic              reset;
  logic [NB-1:0]     btn_n;
  logic              evt_clr;
  logic [NB-1:0]     btn_level, evt_press, evt_long, evt_repeat, evt_release;
  logic [7:0]        evt_cnt;
  logic [NB-1:0][2:0] dbg_state;

  int n_checks = 0;
  int n_errs   = 0;

  btn_event_gen #(
    .NUM_BTN     (NB),
    .CLKS_PER_MS (CPM),
    .DEBOUNCE_MS (DB),
    .LONG_MS     (LG),
    .REPEAT_MS   (RP)
  ) dut (
    .clk27       (clk27),
    .reset       (reset),
    .btn_n       (btn_n),
    .evt_clr     (evt_clr),
    .btn_level   (btn_level),
    .evt_press   (evt_press),
    .evt_long    (evt_long),
    .evt_repeat  (evt_repeat),
    .evt_release (evt_release),
    .evt_cnt     (evt_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk27 = ~clk27;

  // Reference model: a button's debounced level flips once the raw input has
  // disagreed with it for DB counted ticks; the first cycle of any raw change
  // only opens the interval. While agreeing and pressed, ticks accumulate
  // toward LG (first time) or RP (afterwards). Events reach the outputs one
  // clock after they occur.
  int            m_presc;
  int            m_lvl   [NB];
  int            m_dis   [NB];
  int            m_run   [NB];
  int            m_fired [NB];
  logic [NB-1:0] m_pp, m_pl, m_pr, m_prl;
  logic [NB-1:0] m_level, m_sp, m_sl, m_sr, m_srl;
  logic [7:0]    m_cnt;

  always @(posedge clk27 or posedge reset) begin : model
    bit t;
    int p;
    if (reset) begin
      m_presc = 0;
      m_pp = '0; m_pl = '0; m_pr = '0; m_prl = '0;
      m_level = '0; m_sp = '0; m_sl = '0; m_sr = '0; m_srl = '0;
      m_cnt = '0;
      for (int b = 0; b < NB; b++) begin
        m_lvl[b] = 0; m_dis[b] = 0; m_run[b] = 0; m_fired[b] = 0;
      end
    end else begin
      for (int b = 0; b < NB; b++) m_level[b] = (m_lvl[b] != 0);
      m_sp  = (evt_clr ? '0 : m_sp)  | m_pp;
      m_sl  = (evt_clr ? '0 : m_sl)  | m_pl;
      m_sr  = (evt_clr ? '0 : m_sr)  | m_pr;
      m_srl = (evt_clr ? '0 : m_srl) | m_prl;
      m_cnt = m_cnt + 8'($countones({m_pp, m_pl, m_pr, m_prl}));
      t = (m_presc == CPM - 1);
      m_presc = t ? 0 : m_presc + 1;
      m_pp = '0; m_pl = '0; m_pr = '0; m_prl = '0;
      for (int b = 0; b < NB; b++) begin
        p = btn_n[b] ? 0 : 1;
        if (p != m_lvl[b]) begin
          if (m_dis[b] == 0) begin
            m_dis[b] = 1;
            m_run[b] = 0;
          end else if (t) begin
            m_run[b] = m_run[b] + 1;
            if (m_run[b] == DB) begin
              m_lvl[b] = p;
              m_dis[b] = 0;
              m_run[b] = 0;
              if (p != 0) begin
                m_pp[b] = 1'b1;
                m_fired[b] = 0;
              end else begin
                m_prl[b] = 1'b1;
              end
            end
          end
        end else if (m_dis[b] != 0) begin
          m_dis[b] = 0;
          m_run[b] = 0;
        end else if (m_lvl[b] != 0 && t) begin
          m_run[b] = m_run[b] + 1;
          if (m_fired[b] == 0 && m_run[b] == LG) begin
            m_pl[b] = 1'b1;
            m_fired[b] = 1;
            m_run[b] = 0;
          end else if (m_fired[b] != 0 && m_run[b] == RP) begin
            m_pr[b] = 1'b1;
            m_run[b] = 0;
          end
        end
      end
    end
  end

  logic [17:0] dut_all, m_all;
  assign dut_all = {btn_level, evt_press, evt_long, evt_repeat, evt_release, evt_cnt};
  assign m_all   = {m_level, m_sp, m_sl, m_sr, m_srl, m_cnt};

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk27);
  endtask

  task automatic pulse_clr();
    @(negedge clk27);
    evt_clr = 1'b1;
    @(negedge clk27);
    evt_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_n = '1; evt_clr = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (dut_all !== '0) begin
      n_errs++; $display("FAIL reset_outputs: got %h exp %h", dut_all, 18'h0);
    end
    n_checks++;
    if (dbg_state !== '0) begin
      n_errs++; $display("FAIL reset_state: got %h exp 0", dbg_state);
    end
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_clean_press();
    int lat;
    lat = 0;
    btn_n[0] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk27);
      if (lat == 0 && btn_level[0] === 1'b1) lat = c;
    end
    n_checks++;
    if (lat < 13 || lat > 22) begin
      n_errs++; $display("FAIL press_latency: got %0d exp 13..22", lat);
    end
    n_checks++;
    if (evt_press[0] !== 1'b1 || evt_cnt !== 8'd1) begin
      n_errs++; $display("FAIL press_event: got press=%b cnt=%0d exp press=1 cnt=1", evt_press[0], evt_cnt);
    end
    n_checks++;
    if (dut_all !== m_all) begin
      n_errs++; $display("FAIL press_model: got %h exp %h", dut_all, m_all);
    end
    btn_n[0] = 1'b1;
    wait_cycles(30);
    n_checks++;
    if (btn_level !== 2'b00 || evt_release[0] !== 1'b1 || evt_cnt !== 8'd2) begin
      n_errs++; $display("FAIL release_event: got lvl=%b rel=%b cnt=%0d exp lvl=00 rel=1 cnt=2", btn_level, evt_release[0], evt_cnt);
    end
    pulse_clr();
    n_checks++;
    if ({evt_press, evt_long, evt_repeat, evt_release} !== '0 || evt_cnt !== 8'd2) begin
      n_errs++; $display("FAIL clear_flags: got %h exp 0 cnt %0d exp 2", {evt_press, evt_long, evt_repeat, evt_release}, evt_cnt);
    end
  endtask

  task automatic test_glitch();
    btn_n[1] = 1'b0;
    wait_cycles(8);
    btn_n[1] = 1'b1;
    wait_cycles(30);
    n_checks++;
    if (btn_level !== 2'b00 || evt_cnt !== 8'd2 || evt_press !== 2'b00) begin
      n_errs++; $display("FAIL glitch_reject: got lvl=%b press=%b cnt=%0d exp lvl=00 press=00 cnt=2", btn_level, evt_press, evt_cnt);
    end
    n_checks++;
    if (dut_all !== m_all) begin
      n_errs++; $display("FAIL glitch_model: got %h exp %h", dut_all, m_all);
    end
  endtask

  task automatic test_long_repeat();
    int fl, fr;
    fl = 0; fr = 0;
    btn_n[0] = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk27);
      if (fl == 0 && evt_long[0] === 1'b1) fl = c;
      if (fr == 0 && evt_repeat[0] === 1'b1) fr = c;
    end
    n_checks++;
    if (fl < 63 || fl > 72) begin
      n_errs++; $display("FAIL long_latency: got %0d exp 63..72", fl);
    end
    n_checks++;
    if (fr - fl !== 20) begin
      n_errs++; $display("FAIL repeat_spacing: got %0d exp 20", fr - fl);
    end
    n_checks++;
    if (dut_all !== m_all) begin
      n_errs++; $display("FAIL long_model: got %h exp %h", dut_all, m_all);
    end
    btn_n[0] = 1'b1;
    wait_cycles(30);
    n_checks++;
    if (btn_level !== 2'b00 || dut_all !== m_all) begin
      n_errs++; $display("FAIL long_release: got %h exp %h", dut_all, m_all);
    end
    pulse_clr();
  endtask

  task automatic test_release_bounce();
    logic [7:0] base;
    btn_n[1] = 1'b0;
    wait_cycles(30);
    n_checks++;
    if (btn_level[1] !== 1'b1) begin
      n_errs++; $display("FAIL bounce_pressed: got %b exp 1", btn_level[1]);
    end
    pulse_clr();
    base = m_cnt;
    for (int seg = 0; seg < 6; seg++) begin
      btn_n[1] = (seg % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk27);
        n_checks++;
        if (btn_level[1] !== 1'b1 || evt_release[1] !== 1'b0) begin
          n_errs++; $display("FAIL bounce_hold: got lvl=%b rel=%b exp lvl=1 rel=0", btn_level[1], evt_release[1]);
        end
      end
    end
    btn_n[1] = 1'b1;
    wait_cycles(25);
    n_checks++;
    if (btn_level[1] !== 1'b0 || evt_release[1] !== 1'b1 || evt_cnt !== base + 8'd1) begin
      n_errs++; $display("FAIL bounce_release: got lvl=%b rel=%b cnt=%0d exp lvl=0 rel=1 cnt=%0d", btn_level[1], evt_release[1], evt_cnt, base + 8'd1);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 60; seg++) begin
      btn_n = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        evt_clr = ($urandom_range(0, 7) == 0);
        @(negedge clk27);
        n_checks++;
        if (dut_all !== m_all) begin
          n_errs++; $display("FAIL random_model: got %h exp %h", dut_all, m_all);
        end
      end
    end
    evt_clr = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit found, seen;
    found = 0; seen = 0;
    btn_n = '1;
    wait_cycles(40);
    pulse_clr();
    btn_n[0] = 1'b0;
    for (int c = 0; c < 8000 && !found; c++) begin
      @(negedge clk27);
      if (m_cnt == 8'hFE && m_level[0]) found = 1;
    end
    btn_n[0] = 1'b1;
    n_checks++;
    if (!found) begin
      n_errs++; $display("FAIL wrap_setup: got timeout exp cnt reaching fe");
    end
    wait_cycles(40);
    n_checks++;
    if (evt_cnt !== 8'hFF || dut_all !== m_all) begin
      n_errs++; $display("FAIL cnt_ff: got %h cnt=%h exp %h cnt=ff", dut_all, evt_cnt, m_all);
    end
    btn_n = 2'b00;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk27);
      if (m_pp != '0) begin
        evt_clr = 1'b1;
        seen = 1;
      end
    end
    @(negedge clk27);
    evt_clr = 1'b0;
    n_checks++;
    if (!seen) begin
      n_errs++; $display("FAIL simul_press_wait: got timeout exp press pulse");
    end
    n_checks++;
    if (evt_cnt !== 8'h01) begin
      n_errs++; $display("FAIL cnt_wrap: got %h exp 01", evt_cnt);
    end
    n_checks++;
    if (evt_press !== 2'b11 || {evt_long, evt_repeat, evt_release} !== '0) begin
      n_errs++; $display("FAIL clr_vs_set: got press=%b other=%h exp press=11 other=0", evt_press, {evt_long, evt_repeat, evt_release});
    end
    n_checks++;
    if (dut_all !== m_all) begin
      n_errs++; $display("FAIL simul_model: got %h exp %h", dut_all, m_all);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    lat = 0;
    wait_cycles(80);
    n_checks++;
    if (evt_long !== 2'b11 || btn_level !== 2'b11) begin
      n_errs++; $display("FAIL held_before_reset: got long=%b lvl=%b exp 11 11", evt_long, btn_level);
    end
    @(negedge clk27);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (dut_all !== '0 || dbg_state !== '0) begin
      n_errs++; $display("FAIL async_reset: got %h st=%h exp 0", dut_all, dbg_state);
    end
    wait_cycles(2);
    reset = 1'b0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk27);
      if (btn_level === 2'b11) lat = c;
    end
    n_checks++;
    if (lat != 21) begin
      n_errs++; $display("FAIL redebounce_latency: got %0d exp 21", lat);
    end
    n_checks++;
    if (evt_cnt !== 8'd2 || evt_press !== 2'b11 || dut_all !== m_all) begin
      n_errs++; $display("FAIL after_reset: got %h exp %h cnt exp 2", dut_all, m_all);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_repeat();
    test_release_bounce();
    test_random();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
